// File: rtl/alu_issue_pkg.sv
// Shared types, ALU encodings and writeback decode for the ALU issue/writeback controller.
package alu_issue_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FLAGW = 3;
  localparam int unsigned STW   = 3;

  typedef logic [STW-1:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_DRIVE   = 3'd1;
  localparam state_t S_CAPTURE = 3'd2;
  localparam state_t S_RESP    = 3'd3;
  localparam state_t S_TRAP    = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic [FLAGW-1:0] flags;
    logic             wb;
  } resp_t;

  typedef struct packed {
    logic en;
    logic idx;
  } wb_dest_t;

  // Destination operand for a result; only fields 0 and 1 map onto the operand file.
  function automatic wb_dest_t wb_dest(input logic [XLEN-1:0] instr);
    wb_dest_t   d;
    logic       hit;
    logic [4:0] fld;
    hit = 1'b0;
    fld = instr[15:11];
    case (instr[31:26])
      OP_RTYPE: begin
        case (instr[5:0])
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_SLL, FN_SLLV, FN_SRL, FN_SRLV,
          FN_SRA, FN_SRAV, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: hit = 1'b1;
          default: hit = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        hit = 1'b1;
        fld = instr[20:16];
      end
      OP_BEQ, OP_BNE, OP_LW, OP_SW: hit = 1'b0;
      default: hit = 1'b0;
    endcase
    d.en  = hit && (fld < 5'd2);
    d.idx = fld[0];
    return d;
  endfunction

  // Signed-overflow-checked ops that trap instead of writing back.
  function automatic logic is_trap_op(input logic [XLEN-1:0] instr);
    return ((instr[31:26] == OP_RTYPE) && ((instr[5:0] == FN_ADD) || (instr[5:0] == FN_SUB))) ||
           (instr[31:26] == OP_ADDI);
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Instruction queue: power-of-two depth circular buffer with registered full/empty flags.
module alu_issue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push = push & ~full_q;
    do_pop  = pop & ~empty_q;
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

  assign rdata_c = mem_q[rptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller driving a combinational ALU: queues instructions,
// owns the A/B operand file, captures results and returns them on a valid/ready port.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instr,
  input  logic             ld_en,
  input  logic             ld_sel,
  input  logic [XLEN-1:0]  ld_data,
  output logic             ld_ready,
  output logic [XLEN-1:0]  alu_instr,
  output logic [XLEN-1:0]  alu_reg_a,
  output logic [XLEN-1:0]  alu_reg_b,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [FLAGW-1:0] alu_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [FLAGW-1:0] out_flags,
  output logic             out_wb,
  output logic             trap,
  input  logic             trap_clr
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  resp_t           resp_q, resp_d;
  logic            out_valid_q, out_valid_d;
  logic            trap_q, trap_d;

  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [XLEN-1:0] head_c;
  logic            ld_ok;
  wb_dest_t        dest;
  logic            ovf_trap;

  alu_issue_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (in_valid),
    .wdata   (in_instr),
    .pop     (fifo_pop),
    .rdata_c (head_c),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ld_ready = (state_q == S_IDLE) || (state_q == S_TRAP);

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    resp_d      = resp_q;
    out_valid_d = out_valid_q;
    trap_d      = trap_q;
    fifo_pop    = 1'b0;
    ld_ok       = ld_en & ld_ready;
    dest        = wb_dest(instr_q);
    ovf_trap    = is_trap_op(instr_q) & alu_flags[2];

    if (ld_ok) begin
      if (ld_sel) opb_d = ld_data;
      else        opa_d = ld_data;
    end

    case (state_q)
      // A load in the same cycle wins over issuing the queue head.
      S_IDLE: begin
        if (!fifo_empty && !ld_en) begin
          instr_d = head_c;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        fifo_pop      = 1'b1;
        out_valid_d   = 1'b1;
        resp_d.result = alu_result;
        resp_d.flags  = alu_flags;
        resp_d.wb     = 1'b0;
        if (ovf_trap) begin
          trap_d  = 1'b1;
          state_d = S_TRAP;
        end else begin
          resp_d.wb = dest.en;
          if (dest.en) begin
            if (dest.idx) opb_d = alu_result;
            else          opa_d = alu_result;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_TRAP: begin
        if (out_ready) out_valid_d = 1'b0;
        if (trap_clr) begin
          trap_d      = 1'b0;
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      resp_q      <= '0;
      out_valid_q <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      resp_q      <= resp_d;
      out_valid_q <= out_valid_d;
      trap_q      <= trap_d;
    end
  end

  assign in_ready   = ~fifo_full;
  assign alu_instr  = instr_q;
  assign alu_reg_a  = opa_q;
  assign alu_reg_b  = opb_q;
  assign out_valid  = out_valid_q;
  assign out_result = resp_q.result;
  assign out_flags  = resp_q.flags;
  assign out_wb     = resp_q.wb;
  assign trap       = trap_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU stand-in, operand model and response scoreboard.
module tb_alu_issue_ctrl;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        ld_en;
  logic        ld_sel;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [31:0] alu_instr;
  logic [31:0] alu_reg_a;
  logic [31:0] alu_reg_b;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic        out_wb;
  logic        trap;
  logic        trap_clr;

  typedef struct packed {
    logic [31:0] result;
    logic [2:0]  flags;
    logic        wb;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model_a;
  logic [31:0] model_b;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .ld_en      (ld_en),
    .ld_sel     (ld_sel),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .alu_instr  (alu_instr),
    .alu_reg_a  (alu_reg_a),
    .alu_reg_b  (alu_reg_b),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_wb     (out_wb),
    .trap       (trap),
    .trap_clr   (trap_clr)
  );

  // Behavioural ALU: returns {overflow, negative, zero, result}.
  function automatic logic [34:0] alu_fn(input logic [31:0] ins, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r, sx, zx;
    logic        ov;
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    r  = 32'h0;
    ov = 1'b0;
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h20: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
        6'h21: r = a + b;
        6'h22: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
        6'h23: r = a - b;
        6'h00: r = b << ins[10:6];
        6'h04: r = b << a[4:0];
        6'h02: r = b >> ins[10:6];
        6'h06: r = b >> a[4:0];
        6'h03: r = 32'($signed(b) >>> ins[10:6]);
        6'h07: r = 32'($signed(b) >>> a[4:0]);
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2A: r = {31'h0, $signed(a) < $signed(b)};
        6'h2B: r = {31'h0, a < b};
        default: r = 32'h0;
      endcase
    end else begin
      case (ins[31:26])
        6'h08: begin r = a + sx; ov = (a[31] == sx[31]) && (r[31] != a[31]); end
        6'h09: r = a + sx;
        6'h0A: r = {31'h0, $signed(a) < $signed(sx)};
        6'h0B: r = {31'h0, a < sx};
        6'h0C: r = a & zx;
        6'h0D: r = a | zx;
        6'h0E: r = a ^ zx;
        6'h04, 6'h05: r = sx;
        6'h23, 6'h2B: r = a + sx;
        default: r = 32'h0;
      endcase
    end
    return {ov, r[31], (r == 32'h0), r};
  endfunction

  // Expected writeback target: {enable, index}.
  function automatic logic [1:0] tb_dest(input logic [31:0] ins);
    logic [4:0] f;
    logic       ok;
    ok = 1'b0;
    f  = ins[15:11];
    if (ins[31:26] == 6'h00) begin
      ok = ins[5:0] inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22,
                            6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    end else if (ins[31:26] inside {6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E}) begin
      ok = 1'b1;
      f  = ins[20:16];
    end
    return {ok && (f < 5'd2), f[0]};
  endfunction

  function automatic logic tb_trapop(input logic [31:0] ins);
    return ((ins[31:26] == 6'h00) && (ins[5:0] inside {6'h20, 6'h22})) || (ins[31:26] == 6'h08);
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(alu_instr, alu_reg_a, alu_reg_b);

  // Scoreboard: compare each accepted response against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got result=%h flags=%b wb=%b, required no response",
                 out_result, out_flags, out_wb);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_result, out_flags, out_wb} !== {mon_e.result, mon_e.flags, mon_e.wb}) begin
          n_fail++;
          $display("FAIL resp: got result=%h flags=%b wb=%b, required result=%h flags=%b wb=%b",
                   out_result, out_flags, out_wb, mon_e.result, mon_e.flags, mon_e.wb);
        end
      end
    end
  end

  task automatic exp_push(input logic [31:0] w);
    logic [34:0] fr;
    logic [1:0]  d;
    exp_t        e;
    fr       = alu_fn(w, model_a, model_b);
    d        = tb_dest(w);
    e.result = fr[31:0];
    e.flags  = fr[34:32];
    e.wb     = d[1] && !(tb_trapop(w) && fr[34]);
    if (e.wb) begin
      if (d[0]) model_b = e.result;
      else      model_a = e.result;
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Entered and left just after a rising edge; leaves in_valid low.
  task automatic push_instr(input logic [31:0] w);
    int t;
    in_valid = 1'b1;
    in_instr = w;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: in_ready=%b, required 1", in_ready);
    end else begin
      exp_push(w);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load_op(input logic sel, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_data = data;
    cycle(1);
    ld_en = 1'b0;
    if (sel) model_b = data;
    else     model_a = data;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && ld_ready && !out_valid) && t < 300) begin
      cycle(1);
      t++;
    end
    if (t >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: pending=%0d out_valid=%b, required 0/0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b1 || ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b ld_ready=%b, required 1 1", in_ready, ld_ready);
    end
    n_checks++;
    if ({alu_instr, alu_reg_a, alu_reg_b} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_alu: instr=%h a=%h b=%h, required 0", alu_instr, alu_reg_a, alu_reg_b);
    end
    n_checks++;
    if ({out_valid, out_result, out_flags, out_wb, trap} !== 38'h0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b result=%h flags=%b wb=%b trap=%b, required 0",
               out_valid, out_result, out_flags, out_wb, trap);
    end
  endtask

  task automatic test_addu();
    int lat;
    out_ready = 1'b1;
    load_op(1'b0, 32'd5);
    load_op(1'b1, 32'd7);
    push_instr(32'h0001_0021);
    lat = 0;
    while (!out_valid && lat < 20) begin
      cycle(1);
      lat++;
    end
    n_checks++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL addu_latency: got %0d cycles, required 3", lat);
    end
    n_checks++;
    if (alu_reg_a !== 32'd12 || out_wb !== 1'b1) begin
      n_fail++;
      $display("FAIL addu_wb: a=%h wb=%b, required 0000000c 1", alu_reg_a, out_wb);
    end
    wait_idle();
    push_instr(32'h0001_2021);
    wait_idle();
    n_checks++;
    if (alu_reg_a !== 32'd12 || alu_reg_b !== 32'd7) begin
      n_fail++;
      $display("FAIL rd_out_of_range: a=%h b=%h, required 0000000c 00000007", alu_reg_a, alu_reg_b);
    end
  endtask

  task automatic test_trap();
    int t;
    out_ready = 1'b1;
    load_op(1'b0, 32'h7FFF_FFFF);
    load_op(1'b1, 32'h0000_0001);
    push_instr(32'h0001_0820);
    push_instr(32'h0001_0021);
    t = 0;
    while (!trap && t < 30) begin
      cycle(1);
      t++;
    end
    n_checks++;
    if (trap !== 1'b1 || out_flags !== 3'b110 || out_wb !== 1'b0 || alu_reg_b !== 32'h1) begin
      n_fail++;
      $display("FAIL trap_set: trap=%b flags=%b wb=%b b=%h, required 1 110 0 00000001",
               trap, out_flags, out_wb, alu_reg_b);
    end
    cycle(6);
    n_checks++;
    if (trap !== 1'b1 || alu_instr !== 32'h0001_0820 || out_valid !== 1'b0 || ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL trap_hold: trap=%b instr=%h valid=%b ld_ready=%b, required 1 00010820 0 1",
               trap, alu_instr, out_valid, ld_ready);
    end
    trap_clr = 1'b1;
    cycle(1);
    trap_clr = 1'b0;
    n_checks++;
    if (trap !== 1'b0) begin
      n_fail++;
      $display("FAIL trap_clr: trap=%b, required 0", trap);
    end
    wait_idle();
    n_checks++;
    if (alu_reg_a !== 32'h8000_0000 || alu_reg_b !== 32'h1) begin
      n_fail++;
      $display("FAIL trap_resume: a=%h b=%h, required 80000000 00000001", alu_reg_a, alu_reg_b);
    end
    trap_clr = 1'b1;
    cycle(1);
    trap_clr = 1'b0;
    cycle(2);
    n_checks++;
    if (trap !== 1'b0 || ld_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL trap_clr_noop: trap=%b ld_ready=%b valid=%b, required 0 1 0",
               trap, ld_ready, out_valid);
    end
  endtask

  task automatic test_beq();
    push_instr(32'h1000_0010);
    wait_idle();
    n_checks++;
    if (alu_reg_a !== 32'h8000_0000 || alu_reg_b !== 32'h1) begin
      n_fail++;
      $display("FAIL beq_nowb: a=%h b=%h, required 80000000 00000001", alu_reg_a, alu_reg_b);
    end
  endtask

  task automatic test_ori();
    load_op(1'b0, 32'h0000_1200);
    push_instr(32'h3421_00FF);
    wait_idle();
    n_checks++;
    if (alu_reg_b !== 32'h0000_12FF || alu_reg_a !== 32'h0000_1200) begin
      n_fail++;
      $display("FAIL ori_wb: a=%h b=%h, required 00001200 000012ff", alu_reg_a, alu_reg_b);
    end
  endtask

  task automatic test_ld_ignored();
    int t;
    out_ready = 1'b0;
    push_instr(32'h0001_0021);
    t = 0;
    while (!out_valid && t < 20) begin
      cycle(1);
      t++;
    end
    ld_en   = 1'b1;
    ld_sel  = 1'b0;
    ld_data = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if (ld_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ld_ready_busy: ld_ready=%b valid=%b, required 0 1", ld_ready, out_valid);
    end
    cycle(1);
    ld_en = 1'b0;
    n_checks++;
    if (alu_reg_a !== 32'h0000_24FF) begin
      n_fail++;
      $display("FAIL ld_ignored: a=%h, required 000024ff", alu_reg_a);
    end
    out_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int  t;
    logic held_ok;
    out_ready = 1'b0;
    ld_en     = 1'b1;
    ld_sel    = 1'b1;
    ld_data   = 32'h0000_12FF;
    for (int i = 0; i < 4; i++) push_instr(32'h2400_0001);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_full: in_ready=%b, required 0", in_ready);
    end
    in_valid = 1'b1;
    in_instr = 32'h2400_0005;
    held_ok  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) held_ok = 1'b0;
    end
    n_checks++;
    if (held_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL fifth_held: in_ready rose while full, required 0");
    end
    cycle(1);
    ld_en = 1'b0;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL fifth_accept: in_ready=%b, required 1", in_ready);
    end else begin
      exp_push(32'h2400_0005);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    n_checks++;
    if (alu_reg_a !== 32'h0000_2508) begin
      n_fail++;
      $display("FAIL b2b_final_a: a=%h, required 00002508", alu_reg_a);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_valid;
    out_ready = 1'b1;
    push_instr(32'h0001_0021);
    push_instr(32'h2400_0001);
    cycle(1);
    n_checks++;
    if (ld_ready !== 1'b0 || alu_instr !== 32'h0001_0021) begin
      n_fail++;
      $display("FAIL pre_reset_state: ld_ready=%b instr=%h, required 0 00010021", ld_ready, alu_instr);
    end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_a = 32'h0;
    model_b = 32'h0;
    n_checks++;
    if ({out_valid, trap, alu_instr, alu_reg_a, alu_reg_b, out_result} !== 130'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b trap=%b instr=%h a=%h b=%h result=%h in_ready=%b, required 0s and in_ready=1",
               out_valid, trap, alu_instr, alu_reg_a, alu_reg_b, out_result, in_ready);
    end
    cycle(2);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid !== 1'b0 || ld_ready !== 1'b1 || alu_reg_a !== 32'h0 || alu_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL post_reset_quiet: saw_valid=%b ld_ready=%b a=%h instr=%h, required 0 1 0 0",
               saw_valid, ld_ready, alu_reg_a, alu_instr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    ld_en     = 1'b0;
    ld_sel    = 1'b0;
    ld_data   = 32'h0;
    out_ready = 1'b0;
    trap_clr  = 1'b0;
    model_a   = 32'h0;
    model_b   = 32'h0;
    cycle(3);
    rst_n = 1'b1;
    cycle(1);
    test_reset();
    test_addu();
    test_trap();
    test_beq();
    test_ori();
    test_ld_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
